// File: rtl/keyed_mux_reg_if.sv
// Bus bundle for keyed_mux_reg: lookup inputs, mux result and register data path.
interface keyed_mux_reg_if #(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 7,
  parameter int DATA_LEN = 7
) ();
  logic [KEY_LEN-1:0]                   key;
  logic [DATA_LEN-1:0]                  default_out;
  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut;
  logic [DATA_LEN-1:0]                  mux_out;
  logic [DATA_LEN-1:0]                  din;
  logic                                 wen;
  logic [DATA_LEN-1:0]                  q;

  modport master (
    output key, default_out, lut, din, wen,
    input  mux_out, q
  );

  modport slave (
    input  key, default_out, lut, din, wen,
    output mux_out, q
  );
endinterface

// File: rtl/keyed_mux_reg.sv
// Keyed look-up multiplexer (combinational, first match wins) fused with an
// enabled state register with synchronous active-high reset.
module keyed_mux_reg #(
  parameter int                  NR_KEY    = 2,
  parameter int                  KEY_LEN   = 7,
  parameter int                  DATA_LEN  = 7,
  parameter logic [DATA_LEN-1:0] RESET_VAL = '0
) (
  input  logic           clk,
  input  logic           rst,
  keyed_mux_reg_if.slave bus
);
  localparam int P = KEY_LEN + DATA_LEN;
  localparam int W = NR_KEY * P;

  logic [KEY_LEN-1:0]  lut_key  [NR_KEY];
  logic [DATA_LEN-1:0] lut_data [NR_KEY];
  logic [DATA_LEN-1:0] mux_sel;
  logic [DATA_LEN-1:0] q_r;

  // Pair 0 sits at the MSB end of the packed table.
  for (genvar g = 0; g < NR_KEY; g++) begin : g_pair
    assign lut_key[g]  = bus.lut[W-1-g*P -: KEY_LEN];
    assign lut_data[g] = bus.lut[W-1-g*P-KEY_LEN -: DATA_LEN];
  end

  // Scan from the highest index down so the lowest matching index overwrites last.
  always_comb begin
    mux_sel = bus.default_out;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (lut_key[i] == bus.key) begin
        mux_sel = lut_data[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= RESET_VAL;
    end else if (bus.wen) begin
      q_r <= bus.din;
    end
  end

  assign bus.mux_out = mux_sel;
  assign bus.q       = q_r;
endmodule

// File: tb/tb_keyed_mux_reg.sv
// Scoreboard bench for keyed_mux_reg: four instances cover lookup, duplicate keys,
// register reset/enable behaviour and a self-feeding counter loop.
module tb_keyed_mux_reg;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc++;

  logic rst_a = 1'b1;
  logic rst3  = 1'b1;
  logic rst4  = 1'b1;
  logic wen4  = 1'b0;

  keyed_mux_reg_if #(.NR_KEY(2), .KEY_LEN(7), .DATA_LEN(7)) if1 ();
  keyed_mux_reg_if #(.NR_KEY(2), .KEY_LEN(4), .DATA_LEN(8)) if2 ();
  keyed_mux_reg_if #(.NR_KEY(1), .KEY_LEN(4), .DATA_LEN(8)) if3 ();
  keyed_mux_reg_if #(.NR_KEY(1), .KEY_LEN(7), .DATA_LEN(7)) if4 ();

  keyed_mux_reg #(.NR_KEY(2), .KEY_LEN(7), .DATA_LEN(7), .RESET_VAL(7'd0))
    u1 (.clk(clk), .rst(rst_a), .bus(if1.slave));
  keyed_mux_reg #(.NR_KEY(2), .KEY_LEN(4), .DATA_LEN(8), .RESET_VAL(8'h00))
    u2 (.clk(clk), .rst(rst_a), .bus(if2.slave));
  keyed_mux_reg #(.NR_KEY(1), .KEY_LEN(4), .DATA_LEN(8), .RESET_VAL(8'h5A))
    u3 (.clk(clk), .rst(rst3), .bus(if3.slave));
  keyed_mux_reg #(.NR_KEY(1), .KEY_LEN(7), .DATA_LEN(7), .RESET_VAL(7'd0))
    u4 (.clk(clk), .rst(rst4), .bus(if4.slave));

  assign if1.default_out = if1.key + 7'd1;

  // Counter loop: next = lookup(q), default q+1, 66 wraps to 0.
  assign if4.key         = if4.q;
  assign if4.default_out = if4.q + 7'd1;
  assign if4.lut         = {7'd66, 7'd0};
  assign if4.din         = if4.mux_out;
  assign if4.wen         = wen4;

  typedef struct {
    string      name;
    int         inst;
    int         sig;   // 0 = mux_out, 1 = q
    logic [7:0] exp;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  function automatic logic [7:0] actual(int inst, int sig);
    case (inst)
      1: return (sig == 0) ? {1'b0, if1.mux_out} : {1'b0, if1.q};
      2: return (sig == 0) ? if2.mux_out : if2.q;
      3: return (sig == 0) ? if3.mux_out : if3.q;
      default: return (sig == 0) ? {1'b0, if4.mux_out} : {1'b0, if4.q};
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        logic [7:0] a;
        a = actual(sb[i].inst, sb[i].sig);
        checks++;
        if (a !== sb[i].exp) begin
          errors++;
          $display("FAIL %s (cycle %0d): got %h expected %h", sb[i].name, cyc, a, sb[i].exp);
        end
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for cycle %0d never sampled", sb[i].name, sb[i].cyc);
        sb.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(string n, int inst, int sig, logic [7:0] e, int dly);
    exp_t x;
    x.name = n; x.inst = inst; x.sig = sig; x.exp = e; x.cyc = cyc + dly;
    sb.push_back(x);
  endtask

  logic [7:0] m = 8'd0;

  task automatic cnt_step(logic r, logic w, string n);
    tick();
    rst4 = r;
    wen4 = w;
    if (r)      m = 8'd0;
    else if (w) m = (m == 8'd66) ? 8'd0 : m + 8'd1;
    expect_val(n, 4, 1, m, 1);
  endtask

  initial begin
    if1.key = 7'd0; if1.lut = {7'd0, 7'd1, 7'd66, 7'd0}; if1.din = 7'd0; if1.wen = 1'b0;
    if2.key = 4'd0; if2.lut = {4'd3, 8'hAA, 4'd3, 8'h55}; if2.default_out = 8'hC3;
    if2.din = 8'h00; if2.wen = 1'b0;
    if3.key = 4'd0; if3.lut = {4'd7, 8'h3C}; if3.default_out = 8'h00;
    if3.din = 8'h00; if3.wen = 1'b0;

    // Reset values after the first edge with rst high
    tick();
    expect_val("reset_q_u1", 1, 1, 8'h00, 0);
    expect_val("reset_q_u2", 2, 1, 8'h00, 0);
    expect_val("reset_q_u3", 3, 1, 8'h5A, 0);
    expect_val("reset_q_u4", 4, 1, 8'h00, 0);
    rst_a = 1'b0;

    // Basic lookup with default = key+1
    tick(); if1.key = 7'd0;   expect_val("lut_key0",      1, 0, 8'h01, 0);
    tick(); if1.key = 7'd66;  expect_val("lut_key66",     1, 0, 8'h00, 0);
    tick(); if1.key = 7'd5;   expect_val("default_key5",  1, 0, 8'h06, 0);
    tick(); if1.key = 7'd127; expect_val("default_wrap",  1, 0, 8'h00, 0);
    tick(); if1.key = 7'd65;  expect_val("default_key65", 1, 0, 8'h42, 0);

    // Duplicate keys: first listed wins
    tick(); if2.key = 4'd3; expect_val("dup_first_wins", 2, 0, 8'hAA, 0);
    tick(); if2.key = 4'd4; expect_val("dup_default",    2, 0, 8'hC3, 0);
    tick(); if2.lut = {4'd3, 8'hAA, 4'd9, 8'h55}; if2.key = 4'd9;
            expect_val("second_pair", 2, 0, 8'h55, 0);
    tick(); if3.key = 4'd7; expect_val("single_pair", 3, 0, 8'h3C, 0);

    // Register: reset beats wen, then load, hold, single-cycle load
    tick(); rst3 = 1'b1; if3.wen = 1'b1; if3.din = 8'hFF; expect_val("rst_over_wen", 3, 1, 8'h5A, 1);
    tick(); rst3 = 1'b0; if3.wen = 1'b1; if3.din = 8'h11; expect_val("load_11",      3, 1, 8'h11, 1);
    tick(); if3.wen = 1'b0; if3.din = 8'h33; expect_val("hold_1", 3, 1, 8'h11, 1);
    tick(); if3.wen = 1'b0; if3.din = 8'h44; expect_val("hold_2", 3, 1, 8'h11, 1);
    tick(); if3.wen = 1'b0; if3.din = 8'h55; expect_val("hold_3", 3, 1, 8'h11, 1);
    tick(); if3.wen = 1'b1; if3.din = 8'h22; expect_val("load_22",      3, 1, 8'h22, 1);
    tick(); if3.wen = 1'b0; if3.din = 8'h77; expect_val("hold_after_22", 3, 1, 8'h22, 1);
    tick(); rst3 = 1'b1; if3.wen = 1'b1; if3.din = 8'h99; expect_val("abort_load", 3, 1, 8'h5A, 1);
    tick(); rst3 = 1'b0; if3.wen = 1'b1; if3.din = 8'h66; expect_val("load_after_rst", 3, 1, 8'h66, 1);
    tick(); if3.wen = 1'b0;

    // Counter loop: 0..66 then wrap, stop at 10, reset mid-count
    for (int i = 0; i < 67; i++) cnt_step(1'b0, 1'b1, "cnt_run");
    for (int i = 0; i < 10; i++) cnt_step(1'b0, 1'b1, "cnt_to_10");
    for (int i = 0; i < 3; i++)  cnt_step(1'b0, 1'b0, "cnt_hold_10");
    for (int i = 0; i < 5; i++)  cnt_step(1'b0, 1'b1, "cnt_resume");
    cnt_step(1'b1, 1'b1, "cnt_mid_rst");
    for (int i = 0; i < 3; i++)  cnt_step(1'b0, 1'b1, "cnt_after_rst");

    repeat (3) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
